// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the flagged synchronous FIFO.
// Used by fifo_ram and sync_fifo_flags.
package fifo_pkg;

  // Number of storage words for a given pointer width.
  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // The occupancy counter needs one more bit than the pointers so that it can hold DEPTH.
  function automatic int fifo_count_w(input int addr_w);
    return addr_w + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write port, asynchronous read port.
// Contents are not reset; validity is tracked by the pointers in the top level.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have 1-cycle registered latency.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CNT_W = fifo_count_w(ADDR_WIDTH);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  function automatic fifo_status_t status_of(input logic [CNT_W-1:0] c);
    fifo_status_t s;
    s.full         = (c == DEPTH_C);
    s.empty        = (c == '0);
    s.almost_full  = (c >= AF_C);
    s.almost_empty = (c <= AE_C);
    return s;
  endfunction

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_next;
  fifo_status_t          status_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Handshake: a request is a single-cycle strobe and is either accepted or dropped in the
  // same cycle, judged on the registered flags. A read is taken whenever the FIFO holds data;
  // a write is taken when there is room, or when a same-cycle read frees the slot it needs.
  // Dropped requests are reported one cycle later on overflow/underflow.
  assign rd_acc = rd_en & ~status_q.empty;
  assign wr_acc = wr_en & (~status_q.full | rd_acc);

  always_comb begin
    count_next = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_next = count_q + ONE_C;
      2'b01:   count_next = count_q - ONE_C;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      status_q    <= status_of('0);
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q     <= count_next;
      status_q    <= status_of(count_next);
      overflow_q  <= wr_en & ~wr_acc;
      underflow_q <= rd_en & ~rd_acc;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is shown directly; forced to zero while empty so idle output is deterministic.
  assign data_out = status_q.empty ? '0 : ram_rdata;
`else
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (rd_acc) begin
      data_q <= ram_rdata;
    end
  end

  assign data_out = data_q;
`endif

  assign count        = count_q;
  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: reset, underflow, fill/overflow, full read+write, wrap, mid-run reset.
// Data checks adapt to SYNC_FIFO_FWFT_EN (head checked before pop) or registered mode (checked after pop).
module tb_sync_fifo_flags;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int total;
  int bad;

  sync_fifo_flags #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .AF_THRESH (14),
    .AE_THRESH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [4:0] c);
    check({tag, " count"}, 32'(count), 32'(c));
    check({tag, " full"}, 32'(full), 32'(c == 5'd16));
    check({tag, " empty"}, 32'(empty), 32'(c == 5'd0));
    check({tag, " almost_full"}, 32'(almost_full), 32'(c >= 5'd14));
    check({tag, " almost_empty"}, 32'(almost_empty), 32'(c <= 5'd2));
  endtask

  // Pop one word and check it appears with the mode's timing.
  task automatic pop_check(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    check(tag, 32'(data_out), 32'(exp));
    cycle(1'b0, 8'h00, 1'b1);
`else
    cycle(1'b0, 8'h00, 1'b1);
    check(tag, 32'(data_out), 32'(exp));
`endif
  endtask

  // scoreboard
  logic [7:0] exp_q[$];

  initial begin
    logic [7:0] v;
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;

    // 1: reset then idle
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    cycle(1'b0, 8'h00, 1'b0);
    check_flags("reset", 5'd0);
    check("reset data_out", 32'(data_out), 32'h00);
    check("reset overflow", 32'(overflow), 32'h0);
    check("reset underflow", 32'(underflow), 32'h0);

    // 2: read on empty
    cycle(1'b0, 8'h00, 1'b1);
    check("uf pulse", 32'(underflow), 32'h1);
    check("uf count", 32'(count), 32'h0);
    check("uf data_out", 32'(data_out), 32'h00);
    cycle(1'b0, 8'h00, 1'b0);
    check("uf pulse end", 32'(underflow), 32'h0);

    // 3: fill 01..10, then one write too many
    for (int i = 1; i <= 16; i++) begin
      v = 8'(i);
      cycle(1'b1, v, 1'b0);
      exp_q.push_back(v);
      check_flags("fill", 5'(i));
    end
    cycle(1'b1, 8'hAA, 1'b0);
    check("of pulse", 32'(overflow), 32'h1);
    check("of count", 32'(count), 32'd16);
    cycle(1'b0, 8'h00, 1'b0);
    check("of pulse end", 32'(overflow), 32'h0);
    check_flags("of idle", 5'd16);

    // 4: simultaneous read and write while full
    exp_q.push_back(8'h55);
    v = exp_q.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
    check("full rw head", 32'(data_out), 32'(v));
    cycle(1'b1, 8'h55, 1'b1);
`else
    cycle(1'b1, 8'h55, 1'b1);
    check("full rw data", 32'(data_out), 32'(v));
`endif
    check_flags("full rw", 5'd16);
    check("full rw overflow", 32'(overflow), 32'h0);
    while (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      pop_check("drain data", v);
    end
    check_flags("drained", 5'd0);

    // 5: pointer wrap, three rounds of 10 in / 10 out
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 10; k++) begin
        v = 8'(8'h20 + r * 16 + k);
        cycle(1'b1, v, 1'b0);
        exp_q.push_back(v);
      end
      check("wrap count full", 32'(count), 32'd10);
      while (exp_q.size() > 0) begin
        v = exp_q.pop_front();
        pop_check("wrap data", v);
      end
      check_flags("wrap end", 5'd0);
    end

    // 6: reset mid-operation, reset beats a concurrent write
    for (int k = 0; k < 9; k++) begin
      cycle(1'b1, 8'(8'h90 + k), 1'b0);
    end
    check("pre-reset count", 32'(count), 32'd9);
    rst = 1'b1;
    cycle(1'b1, 8'hEE, 1'b0);
    rst = 1'b0;
    check_flags("mid reset", 5'd0);
    check("mid reset data_out", 32'(data_out), 32'h00);
    cycle(1'b1, 8'h3C, 1'b0);
    check_flags("post reset write", 5'd1);
    pop_check("post reset data", 8'h3C);
    check_flags("post reset read", 5'd0);

    // empty with read+write: write only, underflow still pulses
    cycle(1'b1, 8'h77, 1'b1);
    check_flags("empty rw", 5'd1);
    check("empty rw underflow", 32'(underflow), 32'h1);
`ifndef SYNC_FIFO_FWFT_EN
    check("empty rw data hold", 32'(data_out), 32'h3C);
`endif
    pop_check("empty rw data", 8'h77);
    check_flags("final", 5'd0);
    check("final underflow", 32'(underflow), 32'h0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
